// File: rtl/spi_slave_rsp_if.sv
// SPI pin bundle plus fabric-side word handshake for spi_slave_rsp.
// word_cnt is present only when SPI_SLAVE_RSP_WCNT_EN is defined.
interface spi_slave_rsp_if #(
    parameter int DATA_W = 8
);
    logic              s_sck;
    logic              s_mosi;
    logic              s_ss;
    logic              s_miso;
    logic              enable_slave;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_underrun;
    logic              frame_abort;
    logic              busy;
`ifdef SPI_SLAVE_RSP_WCNT_EN
    logic [15:0]       word_cnt;
`endif

    modport slave (
        input  s_sck, s_mosi, s_ss, tx_data, tx_valid,
        output s_miso, enable_slave, rx_data, rx_valid, tx_ready,
        output tx_underrun, frame_abort, busy
`ifdef SPI_SLAVE_RSP_WCNT_EN
        , output word_cnt
`endif
    );

    modport master (
        output s_sck, s_mosi, s_ss, tx_data, tx_valid,
        input  s_miso, enable_slave, rx_data, rx_valid, tx_ready,
        input  tx_underrun, frame_abort, busy
`ifdef SPI_SLAVE_RSP_WCNT_EN
        , input word_cnt
`endif
    );
endinterface

// File: rtl/spi_slave_rsp.sv
// Oversampling SPI mode-0 responder: deserialises MOSI words, serialises a one-entry TX holding register.
// Optional per-frame received-word counter enabled by SPI_SLAVE_RSP_WCNT_EN.
module spi_slave_rsp #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] DUMMY  = '1
) (
    input logic            clk,
    input logic            rst,
    spi_slave_rsp_if.slave bus
);
    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       ACTIVE   = 1'b1;

    logic sck_s1_reg, sck_s2_reg, sck_s3_reg;
    logic ss_s1_reg, ss_s2_reg, ss_s3_reg;
    logic mosi_s1_reg, mosi_s2_reg;
    logic sync_vld_reg, armed_reg;

    // The ss presets look like a high select, so a select already low at reset
    // release would fake a falling edge; armed_reg waits for a genuine high sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1_reg   <= 1'b0;
            sck_s2_reg   <= 1'b0;
            sck_s3_reg   <= 1'b0;
            ss_s1_reg    <= 1'b1;
            ss_s2_reg    <= 1'b1;
            ss_s3_reg    <= 1'b1;
            mosi_s1_reg  <= 1'b0;
            mosi_s2_reg  <= 1'b0;
            sync_vld_reg <= 1'b0;
            armed_reg    <= 1'b0;
        end else begin
            sck_s1_reg   <= bus.s_sck;
            sck_s2_reg   <= sck_s1_reg;
            sck_s3_reg   <= sck_s2_reg;
            ss_s1_reg    <= bus.s_ss;
            ss_s2_reg    <= ss_s1_reg;
            ss_s3_reg    <= ss_s2_reg;
            mosi_s1_reg  <= bus.s_mosi;
            mosi_s2_reg  <= mosi_s1_reg;
            sync_vld_reg <= 1'b1;
            if (sync_vld_reg && ss_s1_reg)
                armed_reg <= 1'b1;
        end
    end

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    assign sck_rise = sck_s2_reg & ~sck_s3_reg;
    assign sck_fall = ~sck_s2_reg & sck_s3_reg;
    assign ss_rise  = ss_s2_reg & ~ss_s3_reg;
    assign ss_fall  = ~ss_s2_reg & ss_s3_reg & armed_reg;

    logic [0:0]        state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-2:0] rx_shift_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              tx_ready_reg;
    logic              word_done_reg;
    logic              rx_valid_reg;
    logic              tx_underrun_reg;
    logic              frame_abort_reg;

    logic              frame_start, word_end;
    logic [DATA_W-1:0] next_word;
    assign frame_start = (state_reg == IDLE) && ss_fall;
    assign word_end    = (state_reg == ACTIVE) && !ss_rise && sck_rise && (bit_cnt_reg == LAST_BIT);
    assign next_word   = tx_ready_reg ? DUMMY : hold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            rx_shift_reg    <= '0;
            tx_shift_reg    <= '0;
            hold_reg        <= '0;
            rx_data_reg     <= '0;
            tx_ready_reg    <= 1'b1;
            word_done_reg   <= 1'b0;
            rx_valid_reg    <= 1'b0;
            tx_underrun_reg <= 1'b0;
            frame_abort_reg <= 1'b0;
        end else begin
            rx_valid_reg    <= 1'b0;
            tx_underrun_reg <= 1'b0;
            frame_abort_reg <= 1'b0;

            if (bus.tx_valid && tx_ready_reg) begin
                hold_reg     <= bus.tx_data;
                tx_ready_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        tx_shift_reg <= next_word;
                        if (tx_ready_reg)
                            tx_underrun_reg <= 1'b1;
                        else
                            tx_ready_reg <= 1'b1;
                        bit_cnt_reg   <= '0;
                        word_done_reg <= 1'b0;
                        state_reg     <= ACTIVE;
                    end
                end
                default: begin
                    // Deselect wins over any sck edge detected in the same cycle.
                    if (ss_rise) begin
                        if (bit_cnt_reg != '0)
                            frame_abort_reg <= 1'b1;
                        bit_cnt_reg   <= '0;
                        word_done_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (sck_rise) begin
                        rx_shift_reg <= {rx_shift_reg[DATA_W-3:0], mosi_s2_reg};
                        if (word_end) begin
                            rx_data_reg   <= {rx_shift_reg, mosi_s2_reg};
                            rx_valid_reg  <= 1'b1;
                            bit_cnt_reg   <= '0;
                            word_done_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        if (word_done_reg) begin
                            tx_shift_reg <= next_word;
                            if (tx_ready_reg)
                                tx_underrun_reg <= 1'b1;
                            else
                                tx_ready_reg <= 1'b1;
                            word_done_reg <= 1'b0;
                        end else begin
                            tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_RSP_WCNT_EN
    logic [15:0] word_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            word_cnt_reg <= '0;
        else if (frame_start)
            word_cnt_reg <= '0;
        else if (word_end && word_cnt_reg != 16'hFFFF)
            word_cnt_reg <= word_cnt_reg + 16'd1;
    end

    assign bus.word_cnt = word_cnt_reg;
`endif

    // Outside a frame MISO idles high; inside, the shifter MSB is the current bit.
    assign bus.s_miso       = (state_reg == ACTIVE) ? tx_shift_reg[DATA_W-1] : 1'b1;
    assign bus.enable_slave = (state_reg == ACTIVE);
    assign bus.busy         = (state_reg == ACTIVE);
    assign bus.rx_data      = rx_data_reg;
    assign bus.rx_valid     = rx_valid_reg;
    assign bus.tx_ready     = tx_ready_reg;
    assign bus.tx_underrun  = tx_underrun_reg;
    assign bus.frame_abort  = frame_abort_reg;
endmodule

// File: tb/tb_spi_slave_rsp.sv
// Directed bench for spi_slave_rsp: bit-banged mode-0 master at clk/16, pulse monitors, immediate-assertion checks.
// Also exercises word_cnt when SPI_SLAVE_RSP_WCNT_EN is defined.
module tb_spi_slave_rsp;
    localparam int HALF = 8;

    logic clk;
    logic rst;

    spi_slave_rsp_if #(.DATA_W(8)) bus ();

    spi_slave_rsp #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    int         rv_cnt = 0;
    int         ur_cnt = 0;
    int         fa_cnt = 0;
    logic       busy_seen = 1'b0;
    logic       en_seen   = 1'b0;
    logic [7:0] rx_hist [16];

    // Counts high cycles of each pulse output, so a pulse of width 1 adds exactly 1.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            if (rv_cnt < 16)
                rx_hist[rv_cnt] = bus.rx_data;
            rv_cnt++;
        end
        if (bus.tx_underrun === 1'b1) ur_cnt++;
        if (bus.frame_abort === 1'b1) fa_cnt++;
        if (bus.busy === 1'b1) busy_seen = 1'b1;
        if (bus.enable_slave === 1'b1) en_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        rv_cnt    = 0;
        ur_cnt    = 0;
        fa_cnt    = 0;
        busy_seen = 1'b0;
        en_seen   = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] d);
        bit done;
        done = 1'b0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bus.tx_ready === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check("tx_write_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic ss_select();
        bus.s_ss = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // sck falls together with ss rising, so the deselect has priority.
    task automatic ss_release();
        bus.s_sck = 1'b0;
        bus.s_ss  = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.s_sck  = 1'b0;
            bus.s_mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            bus.s_sck  = 1'b1;
            mi[7-i]    = bus.s_miso;
            repeat (HALF) @(negedge clk);
        end
    endtask

    logic [7:0] rd0, rd1, rd2;

    initial begin
        rst          = 1'b1;
        bus.s_sck    = 1'b0;
        bus.s_mosi   = 1'b0;
        bus.s_ss     = 1'b1;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_miso",        {31'd0, bus.s_miso},       32'd1);
        check("rst_enable",      {31'd0, bus.enable_slave}, 32'd0);
        check("rst_rx_data",     {24'd0, bus.rx_data},      32'd0);
        check("rst_rx_valid",    {31'd0, bus.rx_valid},     32'd0);
        check("rst_tx_ready",    {31'd0, bus.tx_ready},     32'd1);
        check("rst_underrun",    {31'd0, bus.tx_underrun},  32'd0);
        check("rst_abort",       {31'd0, bus.frame_abort},  32'd0);
        check("rst_busy",        {31'd0, bus.busy},         32'd0);
        repeat (4) @(negedge clk);

        // Single word: A5 preloaded, master sends 3C.
        clear_mon();
        tx_write(8'hA5);
        check("single_tx_full",  {31'd0, bus.tx_ready},     32'd0);
        ss_select();
        check("single_tx_freed", {31'd0, bus.tx_ready},     32'd1);
        check("single_busy",     {31'd0, bus.busy},         32'd1);
        check("single_enable",   {31'd0, bus.enable_slave}, 32'd1);
        xfer_bits(8'h3C, 8, rd0);
        ss_release();
        check("single_miso_word", {24'd0, rd0},             32'hA5);
        check("single_rx_data",  {24'd0, bus.rx_data},      32'h3C);
        check("single_rx_valid", rv_cnt,                    32'd1);
        check("single_underrun", ur_cnt,                    32'd0);
        check("single_abort",    fa_cnt,                    32'd0);
        check("single_idle_en",  {31'd0, bus.enable_slave}, 32'd0);
        check("single_idle_miso", {31'd0, bus.s_miso},      32'd1);

        // Three words back to back, only two supplied by the fabric.
        clear_mon();
        tx_write(8'h11);
        ss_select();
        tx_write(8'h22);
        xfer_bits(8'h01, 8, rd0);
        xfer_bits(8'h02, 8, rd1);
        check("b2b_no_underrun_yet", ur_cnt,                32'd0);
        xfer_bits(8'h03, 8, rd2);
        ss_release();
        check("b2b_read0",       {24'd0, rd0},              32'h11);
        check("b2b_read1",       {24'd0, rd1},              32'h22);
        check("b2b_read2",       {24'd0, rd2},              32'hFF);
        check("b2b_underrun",    ur_cnt,                    32'd1);
        check("b2b_rx_valid",    rv_cnt,                    32'd3);
        check("b2b_rx0",         {24'd0, rx_hist[0]},       32'h01);
        check("b2b_rx1",         {24'd0, rx_hist[1]},       32'h02);
        check("b2b_rx2",         {24'd0, rx_hist[2]},       32'h03);

        // Abort after 5 bits, then a clean frame.
        clear_mon();
        ss_select();
        xfer_bits(8'hA8, 5, rd0);
        ss_release();
        check("abort_pulse",     fa_cnt,                    32'd1);
        check("abort_no_rx",     rv_cnt,                    32'd0);
        check("abort_idle",      {31'd0, bus.busy},         32'd0);
        ss_select();
        xfer_bits(8'hC3, 8, rd0);
        ss_release();
        check("abort_next_rx",   {24'd0, bus.rx_data},      32'hC3);
        check("abort_next_valid", rv_cnt,                   32'd1);
        check("abort_next_fa",   fa_cnt,                    32'd1);

        // Reset in the middle of a frame while ss stays low.
        ss_select();
        tx_write(8'h5A);
        check("midrst_tx_full",  {31'd0, bus.tx_ready},     32'd0);
        xfer_bits(8'hE0, 3, rd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_enable",   {31'd0, bus.enable_slave}, 32'd0);
        check("midrst_miso",     {31'd0, bus.s_miso},       32'd1);
        check("midrst_tx_ready", {31'd0, bus.tx_ready},     32'd1);
        check("midrst_rx_data",  {24'd0, bus.rx_data},      32'd0);
        clear_mon();
        xfer_bits(8'h77, 8, rd0);
        check("midrst_no_rx",    rv_cnt,                    32'd0);
        check("midrst_no_busy",  {31'd0, busy_seen},        32'd0);
        ss_release();
        clear_mon();
        ss_select();
        xfer_bits(8'h96, 8, rd0);
        ss_release();
        check("midrst_new_rx",   {24'd0, bus.rx_data},      32'h96);
        check("midrst_new_valid", rv_cnt,                   32'd1);
        check("midrst_dummy",    {24'd0, rd0},              32'hFF);
        check("midrst_underrun", ur_cnt,                    32'd1);

        // sck activity with ss high must be ignored.
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            bus.s_sck = ~bus.s_sck;
            repeat (HALF) @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        check("idle_no_rx",      rv_cnt,                    32'd0);
        check("idle_no_busy",    {31'd0, busy_seen},        32'd0);
        check("idle_no_enable",  {31'd0, en_seen},          32'd0);

`ifdef SPI_SLAVE_RSP_WCNT_EN
        bus.s_sck = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        ss_select();
        xfer_bits(8'h10, 8, rd0);
        xfer_bits(8'h20, 8, rd0);
        xfer_bits(8'h30, 8, rd0);
        xfer_bits(8'h40, 8, rd0);
        ss_release();
        check("wcnt_after_frame", {16'd0, bus.word_cnt},    32'd4);
        ss_select();
        check("wcnt_cleared",    {16'd0, bus.word_cnt},     32'd0);
        ss_release();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
